// File: rtl/jt51_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jt51_acc_pkg
// Purpose : Shared constants for the JT51 output accumulator.
//           - Carrier masks per connection algorithm, bit order {M1,M2,C1,C2}.
//           - Accumulator width helper (RES+3 bits holds 32 worst-case slots).
// Rev     : 1.0  initial release
// ============================================================================
package jt51_acc_pkg;

    localparam int C_MASK_M1 = 3;
    localparam int C_MASK_M2 = 2;
    localparam int C_MASK_C1 = 1;
    localparam int C_MASK_C2 = 0;

    // Which operators of a channel reach the output for each algorithm.
    localparam logic [3:0] C_CARRIER_MASK [0:7] = '{
        4'b0001,    // con 0
        4'b0001,    // con 1
        4'b0001,    // con 2
        4'b0001,    // con 3
        4'b0011,    // con 4: C1, C2
        4'b0111,    // con 5: M2, C1, C2
        4'b0111,    // con 6: M2, C1, C2
        4'b1111     // con 7: all four
    };

    // 32 slots of (RES-2)-bit signed values need 5 extra bits over RES-2.
    function automatic int acc_width(input int res);
        return res + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt51_acc_side.sv
`default_nettype none
// ============================================================================
// Module  : jt51_acc_side
// Purpose : One stereo side of the output mixer: accumulates the slot
//           contributions of a frame, then saturates and registers the result
//           on the last slot and restarts the sum.
// Ports   : clk, rst, cen       clock, sync reset, clock enable
//           side_en             this side is enabled for the current channel
//           contributes         current slot adds its operand
//           last                current slot is the last of the frame
//           operand             signed (RES-2)-bit slot value
//           sample / xsample    16-bit and RES-bit saturated outputs
// Rev     : 1.0  initial release
// ============================================================================
module jt51_acc_side
    import jt51_acc_pkg::*;
#(
    parameter int RES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  side_en,
    input  logic                  contributes,
    input  logic                  last,
    input  logic signed [RES-3:0] operand,
    output logic signed [15:0]    sample,
    output logic signed [RES-1:0] xsample
);

    localparam int C_ACC_W = acc_width(RES);

    logic signed [C_ACC_W-1:0] acc;
    logic signed [C_ACC_W-1:0] contrib;
    logic signed [C_ACC_W-1:0] sum;
    logic        [C_ACC_W-RES:0] upper;
    logic                      overflow;
    logic signed [RES-1:0]     sat;

    assign contrib = (side_en && contributes)
                   ? {{(C_ACC_W-(RES-2)){operand[RES-3]}}, operand}
                   : '0;
    assign sum     = acc + contrib;

    // The value fits in RES bits only if every bit from the RES-bit sign
    // upward matches.
    assign upper    = sum[C_ACC_W-1:RES-1];
    assign overflow = !((&upper) || (~|upper));
    assign sat      = overflow
                    ? (sum[C_ACC_W-1] ? {1'b1, {(RES-1){1'b0}}}
                                      : {1'b0, {(RES-1){1'b1}}})
                    : sum[RES-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            sample  <= '0;
            xsample <= '0;
        end else if (cen) begin
            if (last) begin
                xsample <= sat;
                sample  <= sat[RES-1 -: 16];
                acc     <= '0;
            end else begin
                acc     <= sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jt51_acc_mixer.sv
`default_nettype none
// ============================================================================
// Module  : jt51_acc_mixer
// Purpose : JT51 output accumulator. Selects carriers per connection
//           algorithm, optionally replaces slot 31 with noise, and sums the
//           32 slots of each frame into saturated stereo samples.
// Ports   : clk, rst, cen                  clock, sync reset, clock enable
//           m1/m2/c1/c2_enters             operator type of current slot
//           op31_acc                       last slot of the frame
//           rl_I, con_I                    channel enables / algorithm
//           op_out                         operator output (RES-2 bits)
//           ne, noise_mix                  noise enable / noise sample
//           left, right                    16-bit outputs
//           xleft, xright                  RES-bit outputs
// Rev     : 1.0  initial release
// ============================================================================
module jt51_acc_mixer
    import jt51_acc_pkg::*;
#(
    parameter int RES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen,
    input  logic                  m1_enters,
    input  logic                  m2_enters,
    input  logic                  c1_enters,
    input  logic                  c2_enters,
    input  logic                  op31_acc,
    input  logic [1:0]            rl_I,
    input  logic [2:0]            con_I,
    input  logic signed [RES-3:0] op_out,
    input  logic                  ne,
    input  logic signed [11:0]    noise_mix,
    output logic signed [15:0]    left,
    output logic signed [15:0]    right,
    output logic signed [RES-1:0] xleft,
    output logic signed [RES-1:0] xright
);

    logic [3:0]            slot_type;
    logic                  is_carrier;
    logic                  use_noise;
    logic                  contributes;
    logic signed [RES-3:0] operand;

    assign slot_type   = {m1_enters, m2_enters, c1_enters, c2_enters};
    assign is_carrier  = |(slot_type & C_CARRIER_MASK[con_I]);

    // Noise takes over slot 31 regardless of the algorithm.
    assign use_noise   = op31_acc && ne;
    assign contributes = use_noise || is_carrier;
    // 12-bit noise scaled up to the operator width.
    assign operand     = use_noise ? {noise_mix, {(RES-14){1'b0}}} : op_out;

    jt51_acc_side #(.RES(RES)) u_left (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .side_en     (rl_I[0]),
        .contributes (contributes),
        .last        (op31_acc),
        .operand     (operand),
        .sample      (left),
        .xsample     (xleft)
    );

    jt51_acc_side #(.RES(RES)) u_right (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .side_en     (rl_I[1]),
        .contributes (contributes),
        .last        (op31_acc),
        .operand     (operand),
        .sample      (right),
        .xsample     (xright)
    );

endmodule
`default_nettype wire

// File: tb/tb_jt51_acc_mixer.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt51_acc_mixer
// Purpose : Directed self-checking bench for jt51_acc_mixer (RES=16).
// Rev     : 1.0  initial release
// ============================================================================
module tb_jt51_acc_mixer;

    localparam int RES = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cen;
    logic                  m1_enters, m2_enters, c1_enters, c2_enters;
    logic                  op31_acc;
    logic [1:0]            rl_I;
    logic [2:0]            con_I;
    logic signed [RES-3:0] op_out;
    logic                  ne;
    logic signed [11:0]    noise_mix;
    logic signed [15:0]    left, right;
    logic signed [RES-1:0] xleft, xright;

    int total = 0;
    int bad   = 0;

    jt51_acc_mixer #(.RES(RES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .m1_enters (m1_enters),
        .m2_enters (m2_enters),
        .c1_enters (c1_enters),
        .c2_enters (c2_enters),
        .op31_acc  (op31_acc),
        .rl_I      (rl_I),
        .con_I     (con_I),
        .op_out    (op_out),
        .ne        (ne),
        .noise_mix (noise_mix),
        .left      (left),
        .right     (right),
        .xleft     (xleft),
        .xright    (xright)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic set_slot(input int s, input logic [2:0] con, input logic [1:0] rl,
                            input int op, input logic n_en, input int noise);
        cen       = 1'b1;
        m1_enters = (s % 4) == 0;
        m2_enters = (s % 4) == 1;
        c1_enters = (s % 4) == 2;
        c2_enters = (s % 4) == 3;
        op31_acc  = (s == 31);
        con_I     = con;
        rl_I      = rl;
        op_out    = op[RES-3:0];
        ne        = n_en;
        noise_mix = noise[11:0];
    endtask

    task automatic idle();
        cen = 1'b1;
        {m1_enters, m2_enters, c1_enters, c2_enters, op31_acc} = '0;
        op_out = '0;
        ne     = 1'b0;
    endtask

    // Drives 32 slots, then one idle cycle; returns on the falling edge
    // after the slot-31 edge.
    task automatic drive_frame(input logic [2:0] con, input logic [1:0] rl,
                               input int op, input logic n_en, input int noise);
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            set_slot(s, con, rl, op, n_en, noise);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_slot(i * 3 + 31, 3'd7, 2'b11, 1234 + i, 1'b1, 77);
            op31_acc = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        total++;
        if (left !== 16'sd0 || right !== 16'sd0 || xleft !== 16'sd0 || xright !== 16'sd0) begin
            bad++;
            $display("FAIL reset_outputs: got l=%0d r=%0d xl=%0d xr=%0d want all 0",
                     left, right, xleft, xright);
        end
        // Partial frame then reset mid-frame: the sum must be discarded.
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            set_slot(s, 3'd7, 2'b11, 500, 1'b0, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        drive_frame(3'd0, 2'b11, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd800 || right !== 16'sd800) begin
            bad++;
            $display("FAIL reset_midframe: got l=%0d r=%0d want 800", left, right);
        end
    endtask

    task automatic test_all_carrier();
        drive_frame(3'd7, 2'b11, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd3200 || right !== 16'sd3200 || xleft !== 16'sd3200 || xright !== 16'sd3200) begin
            bad++;
            $display("FAIL all_carrier: got l=%0d r=%0d xl=%0d xr=%0d want 3200",
                     left, right, xleft, xright);
        end
    endtask

    task automatic test_algorithms();
        drive_frame(3'd0, 2'b11, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd800 || right !== 16'sd800) begin
            bad++;
            $display("FAIL con0: got l=%0d r=%0d want 800", left, right);
        end
        drive_frame(3'd4, 2'b11, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd1600 || right !== 16'sd1600) begin
            bad++;
            $display("FAIL con4: got l=%0d r=%0d want 1600", left, right);
        end
        drive_frame(3'd5, 2'b01, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd2400 || right !== 16'sd0) begin
            bad++;
            $display("FAIL con5_left_only: got l=%0d r=%0d want 2400/0", left, right);
        end
        drive_frame(3'd6, 2'b10, 100, 1'b0, 0);
        total++;
        if (left !== 16'sd0 || right !== 16'sd2400) begin
            bad++;
            $display("FAIL con6_right_only: got l=%0d r=%0d want 0/2400", left, right);
        end
    endtask

    task automatic test_saturation();
        drive_frame(3'd7, 2'b11, 8191, 1'b0, 0);
        total++;
        if (left !== 16'sd32767 || right !== 16'sd32767 || xleft !== 16'sd32767) begin
            bad++;
            $display("FAIL sat_pos: got l=%0d r=%0d xl=%0d want 32767", left, right, xleft);
        end
        drive_frame(3'd7, 2'b11, -8192, 1'b0, 0);
        total++;
        if (left !== -16'sd32768 || right !== -16'sd32768 || xright !== -16'sd32768) begin
            bad++;
            $display("FAIL sat_neg: got l=%0d r=%0d xr=%0d want -32768", left, right, xright);
        end
        drive_frame(3'd7, 2'b11, 1, 1'b0, 0);
        total++;
        if (left !== 16'sd32 || right !== 16'sd32) begin
            bad++;
            $display("FAIL sat_cleared: got l=%0d r=%0d want 32", left, right);
        end
    endtask

    task automatic test_noise();
        drive_frame(3'd0, 2'b11, 100, 1'b1, 256);
        total++;
        if (left !== 16'sd1724 || right !== 16'sd1724) begin
            bad++;
            $display("FAIL noise_on: got l=%0d r=%0d want 1724", left, right);
        end
        drive_frame(3'd0, 2'b11, 100, 1'b0, 256);
        total++;
        if (left !== 16'sd800 || right !== 16'sd800) begin
            bad++;
            $display("FAIL noise_off: got l=%0d r=%0d want 800", left, right);
        end
    endtask

    // Expects the previous frame to have produced 800 on both sides.
    task automatic test_cen_gaps();
        for (int s = 0; s < 32; s++) begin
            @(negedge clk);
            set_slot(s, 3'd7, 2'b11, 100, 1'b0, 0);
            if (s < 31) begin
                @(negedge clk);
                // Garbage on every input while gated, including a fake last slot.
                cen       = 1'b0;
                op_out    = 14'($urandom);
                {m1_enters, m2_enters, c1_enters, c2_enters} = 4'b0001 << (s % 4);
                op31_acc  = (s % 5) == 0;
                ne        = 1'b1;
                noise_mix = 12'($urandom);
                total++;
                if (left !== 16'sd800 || right !== 16'sd800) begin
                    bad++;
                    $display("FAIL cen_hold slot %0d: got l=%0d r=%0d want 800", s, left, right);
                end
            end
        end
        @(negedge clk);
        idle();
        total++;
        if (left !== 16'sd3200 || right !== 16'sd3200) begin
            bad++;
            $display("FAIL cen_result: got l=%0d r=%0d want 3200", left, right);
        end
        // Gated cycles after the update must not disturb the new outputs.
        cen      = 1'b0;
        op31_acc = 1'b1;
        op_out   = 14'sd999;
        c2_enters = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (left !== 16'sd3200 || xright !== 16'sd3200) begin
            bad++;
            $display("FAIL cen_post_hold: got l=%0d xr=%0d want 3200", left, xright);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cen = 1'b0;
        rl_I = 2'b00;
        con_I = 3'd0;
        noise_mix = '0;
        test_reset();
        test_all_carrier();
        test_algorithms();
        test_saturation();
        test_noise();
        test_cen_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
